nco_phase_acc: RTL

NCO_PHASE_ACC -- requirements
Module: nco_phase_acc

---
 rtl/nco_pkg.sv | 51 +++++
 rtl/nco_phase_acc_if.sv | 23 ++
 rtl/nco_inc_ctrl.sv | 67 ++++++
 rtl/nco_phase_acc.sv | 83 ++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared types and elaboration-time real helpers for the NCO phase accumulator
package nco_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } inc_state_t;

    function automatic real real_abs(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    // Casting real to longint rounds, so step back toward zero when it overshoots.
    function automatic longint real_trunc(input real x);
        longint r;
        r = longint'(x);
        if (x >= 0.0 && real'(r) > x) begin
            r = r - 1;
        end else if (x < 0.0 && real'(r) < x) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic real real_fmod(input real a, input real b);
        return a - b * real'(real_trunc(a / b));
    endfunction

    function automatic real real_pow2(input int w);
        real p;
        p = 1.0;
        for (int i = 0; i < w; i++) begin
            p = p * 2.0;
        end
        return p;
    endfunction

    function automatic longint calc_phase_inc(input real f_out, input real f_clk, input int w);
        return real_trunc(real_fmod(f_out / f_clk, 1.0) * real_pow2(w));
    endfunction

    function automatic longint calc_init_phase(input real deg, input int w);
        real d;
        d = real_fmod(deg, 360.0);
        if (d < 0.0) begin
            d = d + 360.0;
        end
        return real_trunc(d / 360.0 * real_pow2(w));
    endfunction

endpackage

// File: rtl/nco_phase_acc_if.sv
// rtl/nco_phase_acc_if.sv - increment-update and phase-stream handshake bundle
interface nco_phase_acc_if #(
    parameter int PHASE_W = 32
);
    logic [PHASE_W-1:0] inc_in;
    logic               inc_valid;
    logic               inc_ready;
    logic [PHASE_W-1:0] phase_out;
    logic               phase_valid;
    logic               phase_ready;
    logic               wrap_stb;
    logic [PHASE_W-1:0] inc_cur;

    modport master (
        output inc_in, inc_valid, phase_ready,
        input  inc_ready, phase_out, phase_valid, wrap_stb, inc_cur
    );

    modport slave (
        input  inc_in, inc_valid, phase_ready,
        output inc_ready, phase_out, phase_valid, wrap_stb, inc_cur
    );
endinterface

// File: rtl/nco_inc_ctrl.sv
// rtl/nco_inc_ctrl.sv - holds a requested increment until the accumulator wraps (or sync),
// so frequency changes land on a cycle boundary of the output waveform.
module nco_inc_ctrl
    import nco_pkg::*;
#(
    parameter int                 PHASE_W = 32,
    parameter logic [PHASE_W-1:0] DEF_INC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_sync,
    input  logic               i_adv,
    input  logic               i_carry,
    input  logic [PHASE_W-1:0] i_inc_in,
    input  logic               i_inc_valid,
    output logic               o_inc_ready,
    output logic [PHASE_W-1:0] o_inc_cur
);

    inc_state_t         r_state;
    inc_state_t         w_state_nxt;
    logic               w_load_pend;
    logic               w_commit;
    logic [PHASE_W-1:0] r_pend_inc;
    logic [PHASE_W-1:0] r_inc_cur;

    always_comb begin
        w_state_nxt = r_state;
        w_load_pend = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_inc_valid) begin
                    w_load_pend = 1'b1;
                    w_state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (i_sync || (i_adv && i_carry)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pend_inc <= '0;
            r_inc_cur  <= DEF_INC;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_pend) begin
                r_pend_inc <= i_inc_in;
            end
            if (w_commit) begin
                r_inc_cur <= r_pend_inc;
            end
        end
    end

    assign o_inc_ready = (r_state == ST_IDLE);
    assign o_inc_cur   = r_inc_cur;

endmodule

// File: rtl/nco_phase_acc.sv
// rtl/nco_phase_acc.sv - numerically controlled oscillator phase accumulator with
// backpressured phase stream and wrap-aligned runtime increment updates.
module nco_phase_acc
    import nco_pkg::*;
#(
    parameter real CLK_FREQ_HZ    = 100.0e6,
    parameter real OUT_FREQ_HZ    = 1.0e6,
    parameter int  PHASE_W        = 32,
    parameter real INIT_PHASE_DEG = 0.0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    nco_phase_acc_if.slave   bus
);

    localparam logic [PHASE_W-1:0] DEF_INC =
        PHASE_W'(calc_phase_inc(OUT_FREQ_HZ, CLK_FREQ_HZ, PHASE_W));
    localparam logic [PHASE_W-1:0] INIT_PH =
        PHASE_W'(calc_init_phase(INIT_PHASE_DEG, PHASE_W));

    if (real_abs(OUT_FREQ_HZ) >= CLK_FREQ_HZ / 2.0 || CLK_FREQ_HZ <= 0.0 ||
        PHASE_W < 4 || PHASE_W > 48) begin : g_bad_param
        $error("nco_phase_acc: OUT_FREQ_HZ must be below Nyquist, CLK_FREQ_HZ positive, PHASE_W in 4..48");
    end

    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_phase_out;
    logic               r_phase_valid;
    logic               r_wrap_stb;
    logic [PHASE_W-1:0] w_inc_cur;
    logic [PHASE_W-1:0] w_sum;
    logic               w_carry;
    logic               w_adv;

    assign w_adv            = en && !sync && (!r_phase_valid || bus.phase_ready);
    assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, w_inc_cur};

    nco_inc_ctrl #(
        .PHASE_W (PHASE_W),
        .DEF_INC (DEF_INC)
    ) u_inc_ctrl (
        .clk         (clk),
        .rst         (rst),
        .i_sync      (sync),
        .i_adv       (w_adv),
        .i_carry     (w_carry),
        .i_inc_in    (bus.inc_in),
        .i_inc_valid (bus.inc_valid),
        .o_inc_ready (bus.inc_ready),
        .o_inc_cur   (w_inc_cur)
    );

    // The output register presents the pre-add value, so the stream starts at INIT_PH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc         <= INIT_PH;
            r_phase_out   <= '0;
            r_phase_valid <= 1'b0;
            r_wrap_stb    <= 1'b0;
        end else begin
            r_wrap_stb <= 1'b0;
            if (sync) begin
                r_acc <= INIT_PH;
            end
            if (w_adv) begin
                r_phase_out   <= r_acc;
                r_phase_valid <= 1'b1;
                r_acc         <= w_sum;
                r_wrap_stb    <= w_carry;
            end else if (bus.phase_ready) begin
                r_phase_valid <= 1'b0;
            end
        end
    end

    assign bus.phase_out   = r_phase_out;
    assign bus.phase_valid = r_phase_valid;
    assign bus.wrap_stb    = r_wrap_stb;
    assign bus.inc_cur     = w_inc_cur;

endmodule
